// File: rtl/mul_seq_pkg.sv
// Shared types for the multiplier request sequencer: FSM state encoding and
// multiplier mode (cm) constants.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] CM_SINGLE8   = 2'b00;
  localparam logic [1:0] CM_DUAL8     = 2'b01;
  localparam logic [1:0] CM_SINGLE16  = 2'b10;
  localparam logic [1:0] CM_RESERVED  = 2'b11;

endpackage

// File: rtl/mul_seq_wait_counter.sv
// Saturating wait-cycle counter with synchronous clear/increment and a
// terminal-count flag against TIMEOUT_CYCLES (evaluated on the next count).
module mul_seq_wait_counter #(
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_next_o,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count_d, count_q;

  // count_next_o is the value including the current cycle, so a capture in
  // this cycle reports the cycle itself.
  always_comb begin
    count_next_o = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
    count_d      = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_next_o;
    end
  end

  assign tc_o = (count_next_o == TC_VAL);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mul_request_sequencer.sv
// Valid/ready front end for the 16x16 multiplier: one transaction in flight.
// Optional macro MUL_SEQ_TIMEOUT_EN aborts WAIT after TIMEOUT_CYCLES.
module mul_request_sequencer
  import mul_seq_pkg::*;
#(
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [15:0]      req_multiplicand_i,
  input  logic [15:0]      req_multiplier_i,
  input  logic [1:0]       req_mode_i,
  output logic [15:0]      mul_multiplicand_o,
  output logic [15:0]      mul_multiplier_o,
  output logic [1:0]       mul_cm_o,
  output logic             mul_enable_o,
  input  logic [31:0]      mul_product_i,
  input  logic             mul_data_valid_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_product_o,
  output logic [1:0]       rsp_mode_o,
  output logic             rsp_error_o,
  output logic [CNT_W-1:0] rsp_cycles_o,
  output logic             busy_o
);

  state_e           state_d, state_q;
  logic [15:0]      a_d, a_q;
  logic [15:0]      b_d, b_q;
  logic [1:0]       mode_d, mode_q;
  logic [31:0]      product_d, product_q;
  logic             error_d, error_q;
  logic [CNT_W-1:0] cycles_d, cycles_q;

  logic             cnt_clear;
  logic             cnt_inc;
  logic [CNT_W-1:0] cnt_next;
  logic             cnt_tc;

  mul_seq_wait_counter #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_counter (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .clear_i      (cnt_clear),
    .inc_i        (cnt_inc),
    .count_next_o (cnt_next),
    .tc_o         (cnt_tc)
  );

`ifndef MUL_SEQ_TIMEOUT_EN
  logic unused_tc;
  assign unused_tc = cnt_tc;
`endif

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    mode_d    = mode_q;
    product_d = product_q;
    error_d   = error_q;
    cycles_d  = cycles_q;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          a_d       = req_multiplicand_i;
          b_d       = req_multiplier_i;
          mode_d    = req_mode_i;
          cnt_clear = 1'b1;
          // Reserved mode is answered locally; the multiplier never sees it.
          if (req_mode_i == CM_RESERVED) begin
            product_d = '0;
            error_d   = 1'b1;
            cycles_d  = '0;
            state_d   = DONE;
          end else begin
            state_d   = ISSUE;
          end
        end
      end
      // A valid left over from the previous operation may still be high here.
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        cnt_inc = 1'b1;
        if (mul_data_valid_i) begin
          product_d = mul_product_i;
          error_d   = 1'b0;
          cycles_d  = cnt_next;
          state_d   = DONE;
        end
`ifdef MUL_SEQ_TIMEOUT_EN
        else if (cnt_tc) begin
          product_d = '0;
          error_d   = 1'b1;
          cycles_d  = cnt_next;
          state_d   = DONE;
        end
`endif
      end
      DONE: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= '0;
      product_q <= '0;
      error_q   <= 1'b0;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mode_q    <= mode_d;
      product_q <= product_d;
      error_q   <= error_d;
      cycles_q  <= cycles_d;
    end
  end

  assign req_ready_o        = (state_q == IDLE);
  assign busy_o             = (state_q != IDLE);
  assign mul_enable_o       = (state_q == ISSUE) || (state_q == WAIT);
  assign rsp_valid_o        = (state_q == DONE);
  assign mul_multiplicand_o = a_q;
  assign mul_multiplier_o   = b_q;
  assign mul_cm_o           = mode_q;
  assign rsp_mode_o         = mode_q;
  assign rsp_product_o      = product_q;
  assign rsp_error_o        = error_q;
  assign rsp_cycles_o       = cycles_q;

endmodule

// File: tb/tb_mul_request_sequencer.sv
// Bench for mul_request_sequencer with a behavioural multiplier stub of
// programmable latency; build with MUL_SEQ_TIMEOUT_EN to exercise the timeout.
module tb_mul_request_sequencer;

  localparam int CNT_W   = 8;
  localparam int TO      = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             reset_ni;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [15:0]      req_multiplicand_i;
  logic [15:0]      req_multiplier_i;
  logic [1:0]       req_mode_i;
  logic [15:0]      mul_multiplicand_o;
  logic [15:0]      mul_multiplier_o;
  logic [1:0]       mul_cm_o;
  logic             mul_enable_o;
  logic [31:0]      mul_product_i;
  logic             mul_data_valid_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [31:0]      rsp_product_o;
  logic [1:0]       rsp_mode_o;
  logic             rsp_error_o;
  logic [CNT_W-1:0] rsp_cycles_o;
  logic             busy_o;

  int vectors     = 0;
  int miscompares = 0;

  int   stub_lat    = 1;
  logic force_dv    = 1'b0;
  int   en_cnt      = 0;
  int   en_hi_total = 0;
  logic real_dv;

  mul_request_sequencer #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i              (clk_i),
    .reset_ni           (reset_ni),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_multiplicand_i (req_multiplicand_i),
    .req_multiplier_i   (req_multiplier_i),
    .req_mode_i         (req_mode_i),
    .mul_multiplicand_o (mul_multiplicand_o),
    .mul_multiplier_o   (mul_multiplier_o),
    .mul_cm_o           (mul_cm_o),
    .mul_enable_o       (mul_enable_o),
    .mul_product_i      (mul_product_i),
    .mul_data_valid_i   (mul_data_valid_i),
    .rsp_valid_o        (rsp_valid_o),
    .rsp_ready_i        (rsp_ready_i),
    .rsp_product_o      (rsp_product_o),
    .rsp_mode_o         (rsp_mode_o),
    .rsp_error_o        (rsp_error_o),
    .rsp_cycles_o       (rsp_cycles_o),
    .busy_o             (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Signed multiplier behaviour for each mode.
  function automatic logic [31:0] mul_ref(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] m);
    int hi, lo;
    case (m)
      2'b00:   return 32'(int'($signed(a[7:0])) * int'($signed(b[7:0])));
      2'b01: begin
        hi = int'($signed(a[15:8])) * int'($signed(b[15:8]));
        lo = int'($signed(a[7:0]))  * int'($signed(b[7:0]));
        return {hi[15:0], lo[15:0]};
      end
      2'b10:   return 32'(int'($signed(a)) * int'($signed(b)));
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit timeout_hit(input logic [1:0] m, input int lat);
`ifdef MUL_SEQ_TIMEOUT_EN
    return (m != 2'b11) && (lat > TO);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_prod(input logic [15:0] a, input logic [15:0] b,
                                           input logic [1:0] m, input int lat);
    if (m == 2'b11 || timeout_hit(m, lat)) return 32'h0;
    return mul_ref(a, b, m);
  endfunction

  function automatic int exp_cycles(input logic [1:0] m, input int lat);
    if (m == 2'b11) return 0;
    if (timeout_hit(m, lat)) return TO;
    return (lat > CNT_MAX) ? CNT_MAX : lat;
  endfunction

  function automatic int exp_dly(input logic [1:0] m, input int lat);
    if (m == 2'b11) return 0;
    if (timeout_hit(m, lat)) return TO + 1;
    return lat + 1;
  endfunction

  // Multiplier stub: valid after stub_lat enabled cycles following the ISSUE cycle.
  always @(posedge clk_i) begin
    en_cnt <= mul_enable_o ? en_cnt + 1 : 0;
    if (mul_enable_o) en_hi_total <= en_hi_total + 1;
  end

  always_comb begin
    real_dv          = mul_enable_o && (en_cnt == stub_lat);
    mul_data_valid_i = real_dv | force_dv;
    mul_product_i    = real_dv ? mul_ref(mul_multiplicand_o, mul_multiplier_o, mul_cm_o)
                               : 32'hBAD0_BAD0;
  end

  task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m,
                         input int lat, input int budget, output int dly, output bit to);
    int g;
    stub_lat = lat;
    req_multiplicand_i = a;
    req_multiplier_i   = b;
    req_mode_i         = m;
    req_valid_i        = 1'b1;
    to = 1'b0;
    g  = 0;
    while (req_ready_o !== 1'b1 && g < 50) begin
      @(posedge clk_i); #1; g++;
    end
    if (g >= 50) to = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    dly = 0;
    while (rsp_valid_o !== 1'b1) begin
      if (dly >= budget) begin to = 1'b1; break; end
      @(posedge clk_i); #1; dly++;
    end
  endtask

  task automatic handshake();
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if ({rsp_valid_o, busy_o, mul_enable_o} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 000", {rsp_valid_o, busy_o, mul_enable_o});
    end
    vectors++;
    if (req_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL reset_ready: got %b expected 1", req_ready_o);
    end
    vectors++;
    if ({mul_multiplicand_o, mul_multiplier_o, mul_cm_o} !== 34'h0) begin
      miscompares++;
      $display("FAIL reset_mul: got %h expected 0", {mul_multiplicand_o, mul_multiplier_o, mul_cm_o});
    end
    vectors++;
    if ({rsp_product_o, rsp_mode_o, rsp_error_o, rsp_cycles_o} !== 43'h0) begin
      miscompares++;
      $display("FAIL reset_rsp: got %h expected 0",
               {rsp_product_o, rsp_mode_o, rsp_error_o, rsp_cycles_o});
    end
  endtask

  task automatic test_fixed();
    logic [15:0] ta [3] = '{16'hFFFE, 16'h0302, 16'h00FF};
    logic [15:0] tb [3] = '{16'h0003, 16'h0405, 16'h0002};
    logic [1:0]  tm [3] = '{2'b10, 2'b01, 2'b00};
    logic [31:0] tp [3] = '{32'hFFFF_FFFA, 32'h000C_000A, 32'hFFFF_FFFE};
    int dly, lat;
    bit to;
    for (int i = 0; i < 3; i++) begin
      lat = $urandom_range(1, 6);
      run_txn(ta[i], tb[i], tm[i], lat, 100, dly, to);
      vectors++;
      if (to) begin miscompares++; $display("FAIL fixed_timeout: vector %0d no response", i); end
      vectors++;
      if (rsp_product_o !== tp[i]) begin
        miscompares++; $display("FAIL fixed_product: got %h expected %h", rsp_product_o, tp[i]);
      end
      vectors++;
      if ({rsp_error_o, rsp_mode_o} !== {1'b0, tm[i]}) begin
        miscompares++;
        $display("FAIL fixed_err_mode: got %b expected %b", {rsp_error_o, rsp_mode_o}, {1'b0, tm[i]});
      end
      vectors++;
      if (rsp_cycles_o !== CNT_W'(lat) || dly != lat + 1) begin
        miscompares++;
        $display("FAIL fixed_cycles: got cycles %0d after %0d edges expected %0d after %0d",
                 rsp_cycles_o, dly, lat, lat + 1);
      end
      handshake();
    end
  endtask

  task automatic test_reserved();
    int en0, dly;
    bit to;
    en0 = en_hi_total;
    run_txn(16'h1234, 16'h5678, 2'b11, 1, 20, dly, to);
    vectors++;
    if (to || dly != 0) begin
      miscompares++; $display("FAIL reserved_latency: got %0d edges (to=%0d) expected 0", dly, to);
    end
    vectors++;
    if ({rsp_product_o, rsp_error_o, rsp_cycles_o, rsp_mode_o} !== {32'h0, 1'b1, 8'h0, 2'b11}) begin
      miscompares++;
      $display("FAIL reserved_rsp: got %h/%b/%0d/%b expected 0/1/0/11",
               rsp_product_o, rsp_error_o, rsp_cycles_o, rsp_mode_o);
    end
    handshake();
    repeat (3) @(posedge clk_i);
    #1;
    vectors++;
    if (en_hi_total != en0) begin
      miscompares++; $display("FAIL reserved_enable: got %0d enable cycles expected 0", en_hi_total - en0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] p0;
    logic [CNT_W-1:0] c0;
    int dly, g, bad;
    bit to;
    run_txn(16'h0102, 16'h0304, 2'b10, 2, 100, dly, to);
    p0 = rsp_product_o;
    c0 = rsp_cycles_o;
    vectors++;
    if (to || p0 !== 32'h0003_0A08) begin
      miscompares++; $display("FAIL b2b_first: got %h expected 00030a08", p0);
    end
    req_multiplicand_i = 16'h0011;
    req_multiplier_i   = 16'h0022;
    req_mode_i         = 2'b10;
    req_valid_i        = 1'b1;
    stub_lat           = 3;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid_o !== 1'b1 || req_ready_o !== 1'b0 || rsp_product_o !== p0 ||
          rsp_cycles_o !== c0 || rsp_error_o !== 1'b0 || rsp_mode_o !== 2'b10) bad++;
      @(posedge clk_i); #1;
    end
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL b2b_hold: got %0d unstable cycles expected 0", bad); end
    handshake();
    vectors++;
    if (req_ready_o !== 1'b1 || busy_o !== 1'b0 || mul_multiplicand_o !== 16'h0102) begin
      miscompares++;
      $display("FAIL b2b_idle: got ready %b busy %b a %h expected 1 0 0102",
               req_ready_o, busy_o, mul_multiplicand_o);
    end
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    vectors++;
    if (busy_o !== 1'b1 || mul_multiplicand_o !== 16'h0011) begin
      miscompares++; $display("FAIL b2b_accept: got busy %b a %h expected 1 0011", busy_o, mul_multiplicand_o);
    end
    g = 0;
    while (rsp_valid_o !== 1'b1 && g < 100) begin @(posedge clk_i); #1; g++; end
    vectors++;
    if (rsp_product_o !== 32'h0000_0242 || rsp_cycles_o !== CNT_W'(3)) begin
      miscompares++;
      $display("FAIL b2b_second: got %h/%0d expected 00000242/3", rsp_product_o, rsp_cycles_o);
    end
    handshake();
  endtask

  task automatic test_stale_valid();
    logic [31:0] exp;
    int g, bad;
    exp = mul_ref(16'h0100, 16'h0007, 2'b10);
    stub_lat = 3;
    req_multiplicand_i = 16'h0100;
    req_multiplier_i   = 16'h0007;
    req_mode_i         = 2'b10;
    req_valid_i        = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    force_dv    = 1'b1;
    @(posedge clk_i); #1;
    force_dv = 1'b0;
    g = 1;
    while (rsp_valid_o !== 1'b1 && g < 100) begin @(posedge clk_i); #1; g++; end
    vectors++;
    if (rsp_product_o !== exp || rsp_cycles_o !== CNT_W'(3) || g != 4) begin
      miscompares++;
      $display("FAIL stale_issue: got %h/%0d at edge %0d expected %h/3 at edge 4",
               rsp_product_o, rsp_cycles_o, g, exp);
    end
    force_dv = 1'b1;
    bad = 0;
    repeat (2) begin
      @(posedge clk_i); #1;
      if (rsp_valid_o !== 1'b1 || rsp_product_o !== exp || rsp_cycles_o !== CNT_W'(3)) bad++;
    end
    force_dv = 1'b0;
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL stale_done: got %0d disturbed cycles expected 0", bad); end
    handshake();
  endtask

  task automatic test_reset_in_wait();
    int seen;
    stub_lat = 50;
    req_multiplicand_i = 16'h4444;
    req_multiplier_i   = 16'h5555;
    req_mode_i         = 2'b01;
    req_valid_i        = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #2;
    reset_ni = 1'b0;
    #1;
    vectors++;
    if ({busy_o, mul_enable_o, rsp_valid_o, req_ready_o} !== 4'b0001 ||
        {mul_multiplicand_o, mul_multiplier_o, mul_cm_o} !== 34'h0 ||
        {rsp_product_o, rsp_mode_o, rsp_error_o, rsp_cycles_o} !== 43'h0) begin
      miscompares++;
      $display("FAIL reset_wait: got busy %b en %b vld %b rdy %b a %h expected 0 0 0 1 0000",
               busy_o, mul_enable_o, rsp_valid_o, req_ready_o, mul_multiplicand_o);
    end
    @(negedge clk_i);
    reset_ni = 1'b1;
    seen = 0;
    repeat (60) begin
      @(posedge clk_i); #1;
      if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) seen++;
    end
    vectors++;
    if (seen != 0) begin miscompares++; $display("FAIL reset_no_rsp: got %0d active cycles expected 0", seen); end
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    logic [1:0]  m;
    int lat, dly, hold;
    bit to;
    for (int i = 0; i < 24; i++) begin
      a    = 16'($urandom);
      b    = 16'($urandom);
      m    = 2'($urandom_range(0, 3));
      lat  = $urandom_range(1, 6);
      hold = $urandom_range(0, 3);
      run_txn(a, b, m, lat, 100, dly, to);
      repeat (hold) begin @(posedge clk_i); #1; end
      vectors++;
      if (to || rsp_valid_o !== 1'b1 || dly != exp_dly(m, lat)) begin
        miscompares++;
        $display("FAIL rand_latency: got %0d edges expected %0d (txn %0d)", dly, exp_dly(m, lat), i);
      end
      vectors++;
      if (rsp_product_o !== exp_prod(a, b, m, lat) || rsp_error_o !== (m == 2'b11) ||
          rsp_mode_o !== m || rsp_cycles_o !== CNT_W'(exp_cycles(m, lat))) begin
        miscompares++;
        $display("FAIL rand_rsp: got %h/%b/%b/%0d expected %h/%b/%b/%0d", rsp_product_o,
                 rsp_error_o, rsp_mode_o, rsp_cycles_o, exp_prod(a, b, m, lat),
                 (m == 2'b11), m, exp_cycles(m, lat));
      end
      vectors++;
      if ({mul_multiplicand_o, mul_multiplier_o, mul_cm_o} !== {a, b, m}) begin
        miscompares++;
        $display("FAIL rand_operands: got %h expected %h",
                 {mul_multiplicand_o, mul_multiplier_o, mul_cm_o}, {a, b, m});
      end
      handshake();
    end
  endtask

`ifdef MUL_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int dly;
    bit to;
    run_txn(16'h0005, 16'h0006, 2'b10, 1000000, 100, dly, to);
    vectors++;
    if (to || dly != TO + 1 || rsp_product_o !== 32'h0 || rsp_error_o !== 1'b1 ||
        rsp_cycles_o !== CNT_W'(TO)) begin
      miscompares++;
      $display("FAIL timeout_abort: got %h/%b/%0d after %0d edges expected 0/1/%0d after %0d",
               rsp_product_o, rsp_error_o, rsp_cycles_o, dly, TO, TO + 1);
    end
    handshake();
    run_txn(16'h0005, 16'h0006, 2'b10, TO, 100, dly, to);
    vectors++;
    if (to || rsp_product_o !== 32'h1E || rsp_error_o !== 1'b0 || rsp_cycles_o !== CNT_W'(TO)) begin
      miscompares++;
      $display("FAIL timeout_valid_wins: got %h/%b/%0d expected 0000001e/0/%0d",
               rsp_product_o, rsp_error_o, rsp_cycles_o, TO);
    end
    handshake();
  endtask
`else
  task automatic test_saturate();
    int dly;
    bit to;
    run_txn(16'h0009, 16'h0009, 2'b00, 300, 1000, dly, to);
    vectors++;
    if (to || dly != 301 || rsp_cycles_o !== CNT_W'(CNT_MAX) || rsp_product_o !== 32'h51 ||
        rsp_error_o !== 1'b0) begin
      miscompares++;
      $display("FAIL saturate: got %0d/%h/%b after %0d edges expected %0d/00000051/0 after 301",
               rsp_cycles_o, rsp_product_o, rsp_error_o, dly, CNT_MAX);
    end
    handshake();
  endtask
`endif

  initial begin
    reset_ni           = 1'b0;
    req_valid_i        = 1'b0;
    req_multiplicand_i = '0;
    req_multiplier_i   = '0;
    req_mode_i         = '0;
    rsp_ready_i        = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    test_reset();
    reset_ni = 1'b1;
    @(posedge clk_i); #1;
    test_fixed();
    test_reserved();
    test_back_to_back();
    test_stale_valid();
    test_reset_in_wait();
    test_random();
`ifdef MUL_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_saturate();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
